// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative MULT/DIV unit holding the HI/LO registers
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, nextState;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opA, opB, accHi, accLo;
    logic               isDiv, negHi, negLo, divZero;

    logic               launch, mtWrite, signA, signB;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum, divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;
    logic [WIDTH-1:0]   stepHi, stepLo, resHi, resLo;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (launch) nextState = RUN;
            RUN:     if (cancel) nextState = IDLE;
                     else if (count == LAST) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Launch decode, one radix-2 step and the sign-corrected final result.
    always_comb begin
        launch  = (state == IDLE) && start && !cancel && !md_op[2];
        mtWrite = (state == IDLE) && start && !cancel && (md_op[2:1] == 2'b10);
        signA   = !md_op[0] && src_a[WIDTH-1];
        signB   = !md_op[0] && src_b[WIDTH-1];
        absA    = signA ? -src_a : src_a;
        absB    = signB ? -src_b : src_b;

        mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? opA : '0)};
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = divShift >= {1'b0, opB};
        divDiff  = divShift[WIDTH-1:0] - opB;

        if (isDiv) begin
            stepHi = divFits ? divDiff : divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], divFits};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end

        prod = {accHi, accLo};
        if (negLo) prod = -prod;
        if (!isDiv) begin
            resHi = prod[2*WIDTH-1:WIDTH];
            resLo = prod[WIDTH-1:0];
        end else if (divZero) begin
            resHi = negHi ? -opA : opA;
            resLo = '1;
        end else begin
            resHi = negHi ? -accHi : accHi;
            resLo = negLo ? -accLo : accLo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            opA     <= '0;
            opB     <= '0;
            accHi   <= '0;
            accLo   <= '0;
            isDiv   <= 1'b0;
            negHi   <= 1'b0;
            negLo   <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (nextState != IDLE);
            case (state)
                IDLE: begin
                    if (launch) begin
                        opA     <= absA;
                        opB     <= absB;
                        accHi   <= '0;
                        accLo   <= md_op[1] ? absA : absB;
                        isDiv   <= md_op[1];
                        divZero <= (src_b == '0);
                        negLo   <= signA ^ signB;
                        negHi   <= md_op[1] & signA;
                        count   <= '0;
                    end
                    if (mtWrite) begin
                        if (md_op[0]) lo <= src_a;
                        else          hi <= src_a;
                    end
                end
                RUN: if (!cancel) begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count + CW'(1);
                end
                FIN: if (!cancel) begin
                    hi   <= resHi;
                    lo   <= resLo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
